// File: rtl/block_lock_pkg.sv
// Shared types and helpers for the 10GBASE-R block-lock controller.
package block_lock_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_TEST = 2'd1,
    S_SLIP = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/ber_monitor.sv
// High bit-error-rate monitor: counts invalid sync headers per fixed cycle window.
module ber_monitor #(
  parameter int BER_WINDOW      = 39063,
  parameter int BER_INVALID_MAX = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inv_hdr_i,
  output logic hi_ber_o
);

  localparam int TMR_W = $clog2(BER_WINDOW);
  localparam int BER_W = $clog2(BER_INVALID_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BER_WINDOW - 1);
  localparam logic [BER_W-1:0] BER_FULL = BER_W'(BER_INVALID_MAX);

  logic [TMR_W-1:0] r_timer;
  logic [BER_W-1:0] r_ber_cnt;
  logic             r_hi_ber;
  logic             w_expire;

  assign w_expire = (r_timer == TMR_LAST);
  assign hi_ber_o = r_hi_ber;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timer   <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else begin
      r_timer <= w_expire ? '0 : r_timer + 1'b1;
      if (r_ber_cnt == BER_FULL) begin
        r_hi_ber <= 1'b1;
      end else if (w_expire) begin
        r_hi_ber <= 1'b0;
      end
      // an invalid header on the expiry cycle belongs to the new window
      if (w_expire) begin
        r_ber_cnt <= {{(BER_W-1){1'b0}}, inv_hdr_i};
      end else if (inv_hdr_i && (r_ber_cnt != BER_FULL)) begin
        r_ber_cnt <= r_ber_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_lock_ctrl.sv
// 10GBASE-R rx block-lock FSM with bit-slip request and descrambler valid gating.
// Optional hi-BER monitor enabled by defining BLOCK_LOCK_HI_BER_EN.
module block_lock_ctrl
  import block_lock_pkg::*;
#(
  parameter int SH_CNT_MAX      = 64,
  parameter int SH_INVALID_MAX  = 16,
  parameter int SLIP_WAIT       = 32,
  parameter int BER_WINDOW      = 39063,
  parameter int BER_INVALID_MAX = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] header_i,
  input  logic       header_vld_i,
  output logic       slip_o,
  output logic       block_lock_o,
  output logic       data_vld_o,
  output logic       hi_ber_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX - 1);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  state_t            r_state;
  logic [SH_W-1:0]   r_sh_cnt;
  logic [INV_W-1:0]  r_inv_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_slip;
  logic              r_block_lock;
  logic [7:0]        r_lock_loss_cnt;
  logic              w_hdr_ok;
  logic              w_inv_hdr;

  assign w_hdr_ok        = sh_valid(header_i);
  assign w_inv_hdr       = header_vld_i & ~w_hdr_ok;
  assign slip_o          = r_slip;
  assign block_lock_o    = r_block_lock;
  assign lock_loss_cnt_o = r_lock_loss_cnt;
  assign data_vld_o      = header_vld_i & r_block_lock;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= S_INIT;
      r_sh_cnt        <= '0;
      r_inv_cnt       <= '0;
      r_wait_cnt      <= '0;
      r_slip          <= 1'b0;
      r_block_lock    <= 1'b0;
      r_lock_loss_cnt <= '0;
    end else begin
      r_slip <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_sh_cnt     <= '0;
          r_inv_cnt    <= '0;
          r_wait_cnt   <= '0;
          r_block_lock <= 1'b0;
          r_state      <= S_TEST;
        end
        S_TEST: begin
          if (header_vld_i) begin
            if (!r_block_lock) begin
              if (!w_hdr_ok) begin
                r_sh_cnt <= '0;
                r_state  <= S_SLIP;
              end else if (r_sh_cnt == SH_LAST) begin
                r_block_lock <= 1'b1;
                r_sh_cnt     <= '0;
                r_inv_cnt    <= '0;
              end else begin
                r_sh_cnt <= r_sh_cnt + 1'b1;
              end
            end else if (!w_hdr_ok && (r_inv_cnt == INV_LAST)) begin
              // loss of lock takes priority over a window rollover on the same header
              r_block_lock <= 1'b0;
              r_sh_cnt     <= '0;
              r_inv_cnt    <= '0;
              r_state      <= S_SLIP;
              if (r_lock_loss_cnt != 8'hFF) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
              end
            end else if (r_sh_cnt == SH_LAST) begin
              r_sh_cnt  <= '0;
              r_inv_cnt <= '0;
            end else begin
              r_sh_cnt <= r_sh_cnt + 1'b1;
              if (!w_hdr_ok) begin
                r_inv_cnt <= r_inv_cnt + 1'b1;
              end
            end
          end
        end
        S_SLIP: begin
          r_slip     <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (header_vld_i) begin
            if (r_wait_cnt == WAIT_LAST) begin
              r_wait_cnt <= '0;
              r_state    <= S_INIT;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

`ifdef BLOCK_LOCK_HI_BER_EN
  ber_monitor #(
    .BER_WINDOW      (BER_WINDOW),
    .BER_INVALID_MAX (BER_INVALID_MAX)
  ) u_ber_monitor (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inv_hdr_i (w_inv_hdr),
    .hi_ber_o  (hi_ber_o)
  );
`else
  logic w_unused_ber;
  assign w_unused_ber = ^{BER_WINDOW, BER_INVALID_MAX, w_inv_hdr};
  assign hi_ber_o     = 1'b0;
`endif

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Self-checking bench for block_lock_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a count-based behavioural model.
module tb_block_lock_ctrl;

  localparam int SH_CNT_MAX = 64;
  localparam int INV_MAX    = 16;
  localparam int SLIP_WAIT  = 32;
  localparam int BER_WIN    = 1000;
  localparam int BER_MAX    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] hdr;
  logic       hv;
  logic       slip_o, block_lock_o, data_vld_o, hi_ber_o;
  logic [7:0] lock_loss_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_slip   = 0;

  block_lock_ctrl #(
    .SH_CNT_MAX      (SH_CNT_MAX),
    .SH_INVALID_MAX  (INV_MAX),
    .SLIP_WAIT       (SLIP_WAIT),
    .BER_WINDOW      (BER_WIN),
    .BER_INVALID_MAX (BER_MAX)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .header_i        (hdr),
    .header_vld_i    (hv),
    .slip_o          (slip_o),
    .block_lock_o    (block_lock_o),
    .data_vld_o      (data_vld_o),
    .hi_ber_o        (hi_ber_o),
    .lock_loss_cnt_o (lock_loss_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks: lock flag, consecutive good headers while hunting, header/invalid tallies
  // of the current 64-header window while locked, and the "dead time" after a slip
  // (one slip cycle, SLIP_WAIT header beats, one restart cycle) during which input is ignored.
  int m_edge      = 0;
  int m_slip_edge = -10;
  int m_skip      = 0;
  int m_wait      = 0;
  int m_good      = 0;
  int m_win       = 0;
  int m_bad       = 0;
  int m_loss      = 0;
  int m_tmr       = 0;
  int m_bc        = 0;
  bit m_lock      = 1'b0;
  bit m_hi        = 1'b0;

  function automatic bit hdr_ok(input logic [1:0] h);
    return h[1] ^ h[0];
  endfunction

  task automatic m_trigger_slip();
    m_slip_edge = m_edge + 1;
    m_skip      = 1;
    m_wait      = SLIP_WAIT;
    m_good      = 0;
    m_win       = 0;
    m_bad       = 0;
  endtask

  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      m_lock = 0; m_loss = 0; m_good = 0; m_win = 0; m_bad = 0;
      m_skip = 1; m_wait = 0; m_slip_edge = -10;
      m_tmr = 0; m_bc = 0; m_hi = 0;
    end else begin
`ifdef BLOCK_LOCK_HI_BER_EN
      begin
        bit expire, bad;
        expire = (m_tmr == BER_WIN - 1);
        bad    = hv && !hdr_ok(hdr);
        m_tmr  = expire ? 0 : m_tmr + 1;
        if (m_bc >= BER_MAX) m_hi = 1;
        else if (expire)     m_hi = 0;
        if (expire)                    m_bc = bad ? 1 : 0;
        else if (bad && m_bc < BER_MAX) m_bc++;
      end
`endif
      if (m_skip > 0) begin
        m_skip--;
      end else if (m_wait > 0) begin
        if (hv) begin
          m_wait--;
          if (m_wait == 0) m_skip = 1;
        end
      end else if (hv) begin
        if (!m_lock) begin
          if (!hdr_ok(hdr)) m_trigger_slip();
          else begin
            m_good++;
            if (m_good == SH_CNT_MAX) begin
              m_lock = 1; m_good = 0; m_win = 0; m_bad = 0;
            end
          end
        end else begin
          m_win++;
          if (!hdr_ok(hdr)) m_bad++;
          if (m_bad == INV_MAX) begin
            m_lock = 0;
            if (m_loss < 255) m_loss++;
            m_trigger_slip();
          end else if (m_win == SH_CNT_MAX) begin
            m_win = 0; m_bad = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_edge > 0) begin
      chk("slip", slip_o, (m_edge == m_slip_edge));
      chk("block_lock", block_lock_o, m_lock);
      chk("lock_loss_cnt", lock_loss_o, m_loss);
      chk("hi_ber", hi_ber_o, m_hi);
      chk("data_vld", data_vld_o, hv & m_lock);
      if (slip_o === 1'b1) n_slip++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [1:0] h);
    hv  = v;
    hdr = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    rst = 1'b0;
    step(1'b0, 2'b00);
  endtask

  int s0;
  int err_tab [8] = '{0, 1, 5, 30, 0, 60, 2, 0};
  int vld_tab [4] = '{100, 50, 100, 80};

  initial begin
    rst = 1'b1; hv = 1'b0; hdr = 2'b00;
    @(posedge clk); #1;

    // lock acquisition from reset
    do_reset();
    chk("rst_lock", block_lock_o, 0);
    chk("rst_slip", slip_o, 0);
    chk("rst_loss", lock_loss_o, 0);
    chk("rst_hiber", hi_ber_o, 0);
    s0 = n_slip;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 2'b01);
      if (i == 62) chk("lock_after_63", block_lock_o, 0);
    end
    chk("lock_after_64", block_lock_o, 1);
    chk("no_slip_on_lock", n_slip - s0, 0);

    // unlocked slip and relock
    do_reset();
    s0 = n_slip;
    for (int i = 0; i < 9; i++) step(1'b1, 2'b10);
    step(1'b1, 2'b00);
    chk("slip_c1", slip_o, 0);
    step(1'b0, 2'b00);
    chk("slip_c2", slip_o, 1);
    step(1'b0, 2'b00);
    chk("slip_c3", slip_o, 0);
    for (int i = 0; i < 32; i++) step(1'b1, 2'b00);
    for (int i = 0; i < 64; i++) step(1'b1, 2'b01);
    chk("relock_early", block_lock_o, 0);
    step(1'b1, 2'b01);
    chk("relock", block_lock_o, 1);
    chk("one_slip", n_slip - s0, 1);

    // loss-of-lock threshold
    for (int i = 0; i < 64; i++) step(1'b1, (i < 15) ? 2'b00 : 2'b01);
    chk("15_bad_lock", block_lock_o, 1);
    chk("15_bad_loss", lock_loss_o, 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'b11);
      if (i == 14) chk("bad15_hold", block_lock_o, 1);
    end
    chk("16_bad_lock", block_lock_o, 0);
    chk("16_bad_loss", lock_loss_o, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00);
    chk("loss_slip", n_slip - s0, 2);

    // relock, then reset mid-operation
    for (int i = 0; i < 32; i++) step(1'b1, 2'b11);
    for (int i = 0; i < 65; i++) step(1'b1, 2'b10);
    chk("relock2", block_lock_o, 1);
    chk("relock2_loss", lock_loss_o, 1);
    rst = 1'b1;
    step(1'b1, 2'b01);
    chk("midrst_lock", block_lock_o, 0);
    chk("midrst_loss", lock_loss_o, 0);
    chk("midrst_slip", slip_o, 0);
    chk("midrst_dvld", data_vld_o, 0);
    rst = 1'b0;

    // gapped valid
    do_reset();
    hv = 1'b1; hdr = 2'b01; #1;
    chk("dvld_unlocked", data_vld_o, 0);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("gap_lock_63", block_lock_o, 0);
      step(1'b1, 2'b01);
      step(1'b0, 2'($urandom));
      step(1'b0, 2'($urandom));
    end
    chk("gap_lock", block_lock_o, 1);
    hv = 1'b1; hdr = 2'b01; #1;
    chk("dvld_locked_hi", data_vld_o, 1);
    hv = 1'b0; #1;
    chk("dvld_locked_lo", data_vld_o, 0);
    for (int i = 0; i < 30; i++) step(1'b1, 2'b10);

    // randomized traffic with varying error and valid density
    for (int seg = 0; seg < 16; seg++) begin
      int err, vp;
      err = err_tab[seg % 8];
      vp  = vld_tab[seg % 4];
      if (seg == 9) begin
        rst = 1'b1;
        step(1'b1, 2'b01);
        rst = 1'b0;
      end
      for (int c = 0; c < 300; c++) begin
        logic b, v;
        logic [1:0] h;
        b = 1'($urandom);
        v = ($urandom % 100) < vp;
        h = (($urandom % 100) < err) ? {b, b} : {b, ~b};
        step(v, h);
      end
    end

`ifdef BLOCK_LOCK_HI_BER_EN
    // hi-BER set inside a window, cleared after a clean window
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 2'b00);
    chk("hiber_pre", hi_ber_o, 0);
    step(1'b0, 2'b00);
    chk("hiber_set", hi_ber_o, 1);
    for (int i = 0; i < 1500; i++) step(1'b0, 2'b00);
    chk("hiber_hold", hi_ber_o, 1);
    for (int i = 0; i < 700; i++) step(1'b0, 2'b00);
    chk("hiber_clear", hi_ber_o, 0);
`endif

    step(1'b0, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
